phase_sequencer: RTL and testbench

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/phase_sequencer.sv | 132 +++++++++++++
 tb/tb_phase_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// ---------------------------------------------------------------------------
// phase_sequencer
//   Stepper-motor phase sequencer. While run is high the sequencer walks an
//   8-entry phase table (half-step wave/two-coil pattern) at a programmable
//   rate, tracking a signed position in half-step units.
//
// Ports
//   clk        : motor clock, all state changes on rising edge
//   rst        : asynchronous, active-low reset
//   run        : level-sensitive move request
//   step       : 1 = full step, 0 = half step
//   dir        : 1 = forward (index +), 0 = reverse (index -)
//   rate_div   : phase period minus one, in clk cycles
//   hold_en    : 1 = keep coils energized after a move
//   coils      : coil drive pattern {A,B,C,D}
//   step_pulse : one-cycle pulse per phase advance
//   position   : signed position, half-step units, wraps mod 2^POS_W
//   busy       : high while in RUN
//   done       : one-cycle pulse after leaving RUN
// ---------------------------------------------------------------------------
module phase_sequencer #(
    parameter int unsigned POS_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             dir,
    input  logic [7:0]       rate_div,
    input  logic             hold_en,
    output logic [3:0]       coils,
    output logic             step_pulse,
    output logic [POS_W-1:0] position,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [7:0]       count, count_next;
    logic [2:0]       idx, idx_next;
    logic [POS_W-1:0] pos, pos_next;
    logic             pulse_next;
    logic             done_next;
    logic             hold_valid, hold_next;
    logic [2:0]       delta;
    logic [3:0]       pattern;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= '0;
            idx        <= '0;
            pos        <= '0;
            step_pulse <= 1'b0;
            done       <= 1'b0;
            hold_valid <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            idx        <= idx_next;
            pos        <= pos_next;
            step_pulse <= pulse_next;
            done       <= done_next;
            hold_valid <= hold_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        idx_next   = idx;
        pos_next   = pos;
        pulse_next = 1'b0;
        done_next  = 1'b0;
        hold_next  = hold_valid;
        // Full step from an odd (two-coil) index jumps two; from an even
        // (single-coil) index it moves one to realign onto a two-coil phase.
        delta      = (step && idx[0]) ? 3'd2 : 3'd1;

        case (state)
            IDLE: begin
                if (run) begin
                    state_next = RUN;
                    count_next = '0;
                end
            end
            RUN: begin
                // Dropping run wins over a terminal count in the same cycle.
                if (!run) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    hold_next  = 1'b1;
                end else if (count >= rate_div) begin
                    count_next = '0;
                    pulse_next = 1'b1;
                    if (dir) begin
                        idx_next = idx + delta;
                        pos_next = pos + POS_W'(delta);
                    end else begin
                        idx_next = idx - delta;
                        pos_next = pos - POS_W'(delta);
                    end
                end else begin
                    count_next = count + 8'd1;
                end
            end
        endcase
    end

    always_comb begin
        case (idx)
            3'd0:    pattern = 4'b1000;
            3'd1:    pattern = 4'b1100;
            3'd2:    pattern = 4'b0100;
            3'd3:    pattern = 4'b0110;
            3'd4:    pattern = 4'b0010;
            3'd5:    pattern = 4'b0011;
            3'd6:    pattern = 4'b0001;
            default: pattern = 4'b1001;
        endcase
        coils = ((state == RUN) || (hold_en && hold_valid)) ? pattern : '0;
    end

    assign busy     = (state == RUN);
    assign position = pos;

endmodule

// File: tb/tb_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_phase_sequencer
//   Directed stimulus for phase_sequencer. A cycle model pushes expected
//   outputs to a scoreboard queue after each clock edge; they are popped and
//   compared against the DUT. Scenario-specific constant checks are added
//   at the interesting points (wraps, realignment, reset, rate change).
// ---------------------------------------------------------------------------
module tb_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        dir = 1'b1;
    logic [7:0]  rate_div = 8'd0;
    logic        hold_en = 1'b0;
    logic [3:0]  coils;
    logic        step_pulse;
    logic [15:0] position;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    phase_sequencer #(.POS_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .step       (step),
        .dir        (dir),
        .rate_div   (rate_div),
        .hold_en    (hold_en),
        .coils      (coils),
        .step_pulse (step_pulse),
        .position   (position),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  coils;
        logic        pulse;
        logic [15:0] pos;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t sb[$];

    // cycle model
    bit          m_run;
    int          m_cnt;
    int          m_idx;
    logic [15:0] m_pos;
    bit          m_pulse;
    bit          m_done;
    bit          m_hold;

    function automatic logic [3:0] pat(input int i);
        logic [3:0] tbl [8];
        tbl = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                4'b0010, 4'b0011, 4'b0001, 4'b1001};
        return tbl[i];
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_cnt = 0; m_idx = 0; m_pos = '0;
        m_pulse = 0; m_done = 0; m_hold = 0;
    endtask

    task automatic model_step();
        int d;
        m_pulse = 0;
        m_done  = 0;
        if (!m_run) begin
            if (run) begin
                m_run = 1;
                m_cnt = 0;
            end
        end else if (!run) begin
            m_run  = 0;
            m_done = 1;
            m_hold = 1;
        end else if (m_cnt >= int'(rate_div)) begin
            d = (step && (m_idx % 2 == 1)) ? 2 : 1;
            if (!dir) d = -d;
            m_idx   = (m_idx + d + 8) % 8;
            m_pos   = 16'(int'(m_pos) + d);
            m_cnt   = 0;
            m_pulse = 1;
        end else begin
            m_cnt++;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.coils = (m_run || (hold_en && m_hold)) ? pat(m_idx) : 4'b0000;
        e.pulse = m_pulse;
        e.pos   = m_pos;
        e.busy  = m_run;
        e.done  = m_done;
        return e;
    endfunction

    task automatic compare_sb();
        exp_t e;
        e = sb.pop_front();
        check("coils",      16'(coils),      16'(e.coils));
        check("step_pulse", 16'(step_pulse), 16'(e.pulse));
        check("position",   position,        e.pos);
        check("busy",       16'(busy),       16'(e.busy));
        check("done",       16'(done),       16'(e.done));
        check("pulse_done_excl", 16'(step_pulse & done), 16'(0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst) model_reset();
        else      model_step();
        sb.push_back(model_out());
        compare_sb();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [3:0]  seq_half [4];
        logic [3:0]  seq_full [5];
        logic [15:0] pos_full [5];
        seq_half = '{4'b1100, 4'b0100, 4'b0110, 4'b0010};
        seq_full = '{4'b1100, 4'b0110, 4'b0011, 4'b1001, 4'b1100};
        pos_full = '{16'd1, 16'd3, 16'd5, 16'd7, 16'd9};

        // reset state
        model_reset();
        #12;
        check("rst_coils",    16'(coils),      16'(0));
        check("rst_pulse",    16'(step_pulse), 16'(0));
        check("rst_position", position,        16'(0));
        check("rst_busy",     16'(busy),       16'(0));
        check("rst_done",     16'(done),       16'(0));
        @(negedge clk);
        rst = 1'b1;
        tick();

        // half step forward, rate_div=3
        step = 0; dir = 1; rate_div = 8'd3; hold_en = 0; run = 1;
        tick();
        check("half_entry_coils", 16'(coils), 16'(4'b1000));
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("half_pulse", 16'(step_pulse), 16'((k % 4) == 0));
            if ((k % 4) == 0)
                check("half_coils", 16'(coils), 16'(seq_half[k/4 - 1]));
        end
        check("half_position", position, 16'd4);
        run = 0;
        tick();
        check("half_done",        16'(done),  16'(1));
        check("half_exit_coils",  16'(coils), 16'(0));
        tick();
        check("half_done_once",   16'(done),  16'(0));

        // full step realignment from index 0, rate_div=0
        do_reset();
        step = 1; dir = 1; rate_div = 8'd0; run = 1;
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("full_coils",    16'(coils), 16'(seq_full[k]));
            check("full_position", position,   pos_full[k]);
        end
        run = 0;
        tick();

        // reverse wrap 0 -> 7
        do_reset();
        step = 0; dir = 0; rate_div = 8'd0; run = 1;
        tick();
        tick();
        check("rev_coils",    16'(coils), 16'(4'b1001));
        check("rev_position", position,   16'hFFFF);
        run = 0;
        tick();

        // run falls on terminal count, hold_en=1
        hold_en = 1; step = 0; dir = 1; rate_div = 8'd3; run = 1;
        tick();
        for (int k = 0; k < 3; k++) tick();
        run = 0;
        tick();
        check("term_pulse",    16'(step_pulse), 16'(0));
        check("term_position", position,        16'hFFFF);
        check("term_done",     16'(done),       16'(1));
        check("term_hold",     16'(coils),      16'(4'b1001));
        // immediate re-entry keeps index/position, count restarts
        run = 1;
        tick();
        check("reenter_busy", 16'(busy), 16'(1));
        for (int k = 1; k <= 4; k++) tick();
        check("reenter_pulse",    16'(step_pulse), 16'(1));
        check("reenter_position", position,        16'd0);
        for (int k = 0; k < 3; k++) tick();
        run = 0; hold_en = 0;
        tick();
        check("term2_pulse",    16'(step_pulse), 16'(0));
        check("term2_position", position,        16'd0);
        check("term2_coils",    16'(coils),      16'(0));
        tick();

        // async reset mid-move
        do_reset();
        step = 0; dir = 1; rate_div = 8'd0; run = 1;
        tick();
        for (int k = 0; k < 5; k++) tick();
        check("mid_position", position, 16'd5);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("arst_coils",    16'(coils),      16'(0));
        check("arst_pulse",    16'(step_pulse), 16'(0));
        check("arst_position", position,        16'(0));
        check("arst_busy",     16'(busy),       16'(0));
        check("arst_done",     16'(done),       16'(0));
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("release_busy",     16'(busy), 16'(1));
        check("release_position", position,  16'd0);
        run = 0;
        tick();

        // rate_div lowered below current count
        step = 0; dir = 1; rate_div = 8'd200; run = 1;
        tick();
        for (int k = 0; k < 50; k++) tick();
        check("rate_no_pulse", 16'(step_pulse), 16'(0));
        rate_div = 8'd2;
        tick();
        check("rate_first_pulse", 16'(step_pulse), 16'(1));
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("rate_period", 16'(step_pulse), 16'((k % 3) == 0));
        end
        run = 0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
